// File: rtl/write_back_multi_port.sv
// Write-back stage: multi-port register commit, RIP/fetch-PC tracking,
// retriggerable multi-cycle flush and a saturating redirect counter.
module write_back_multi_port #(
    parameter int          NUM_WB       = 2,
    parameter int          REG_N        = 32,
    parameter int          DATA_W       = 64,
    parameter int          LOAD_LATENCY = 1,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          RIP_IDX      = 16,
    parameter int          EFL_IDX      = 17,
    parameter int          RSP_IDX      = 4,
    parameter int          RBP_IDX      = 5,
    parameter logic [63:0] INIT_RIP     = 64'd0,
    parameter logic [63:0] INIT_RSP     = 64'd1024,
    localparam int         IW           = (REG_N > 1) ? $clog2(REG_N) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WB-1:0]          wb_valid_i,
    input  logic [NUM_WB*IW-1:0]       wb_idx_i,
    input  logic [NUM_WB*DATA_W-1:0]   wb_data_i,
    input  logic                       efl_we_i,
    input  logic [DATA_W-1:0]          efl_data_i,
    input  logic                       br_taken_i,
    input  logic [DATA_W-1:0]          br_target_i,
    input  logic                       stall_pc_i,
    output logic [REG_N*DATA_W-1:0]    gpr_o,
    output logic [DATA_W-1:0]          pc_to_mem_o,
    output logic [DATA_W-1:0]          pc_to_fet_o,
    output logic                       flush_o,
    output logic [31:0]                redirect_cnt_o
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    // RIP starts LOAD_LATENCY behind so the first PC leaving memory is INIT_RIP.
    localparam logic [DATA_W-1:0] RIP_RST = DATA_W'(INIT_RIP) - DATA_W'(LOAD_LATENCY);
    localparam logic [DATA_W-1:0] RSP_RST = DATA_W'(INIT_RSP);

    logic [DATA_W-1:0] rf    [REG_N];
    logic [DATA_W-1:0] pcq   [LOAD_LATENCY];
    logic [DATA_W-1:0] rip_d;
    logic [FW-1:0]     fc_q, fc_d;
    logic [31:0]       cnt_q, cnt_d;

    assign pc_to_mem_o    = rf[RIP_IDX];
    assign pc_to_fet_o    = pcq[LOAD_LATENCY-1];
    assign flush_o        = (fc_q != '0);
    assign redirect_cnt_o = cnt_q;

    always_comb begin
        rip_d = pc_to_mem_o + DATA_W'(1);
        if (br_taken_i) begin
            rip_d = br_target_i;
        end else if (stall_pc_i) begin
            rip_d = pc_to_fet_o;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < REG_N; gi++) begin : g_reg
            logic [DATA_W-1:0] reg_q;
            logic [DATA_W-1:0] reg_d;

            if (gi == RIP_IDX) begin : g_rip
                assign reg_d = rip_d;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) reg_q <= RIP_RST;
                    else     reg_q <= reg_d;
                end
            end else begin : g_arch
                // Later ports overwrite earlier ones; EFLAGS strobe overrides all ports.
                always_comb begin
                    reg_d = reg_q;
                    for (int k = 0; k < NUM_WB; k++) begin
                        if (wb_valid_i[k] && (wb_idx_i[k*IW +: IW] == IW'(gi))) begin
                            reg_d = wb_data_i[k*DATA_W +: DATA_W];
                        end
                    end
                    if ((gi == EFL_IDX) && efl_we_i) begin
                        reg_d = efl_data_i;
                    end
                end
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) reg_q <= ((gi == RSP_IDX) || (gi == RBP_IDX)) ? RSP_RST : '0;
                    else     reg_q <= reg_d;
                end
            end

            assign rf[gi] = reg_q;
            assign gpr_o[gi*DATA_W +: DATA_W] = reg_q;
        end

        for (gi = 0; gi < LOAD_LATENCY; gi++) begin : g_pcq
            logic [DATA_W-1:0] stage_q;
            logic [DATA_W-1:0] stage_d;

            if (gi == 0) begin : g_head
                assign stage_d = stall_pc_i ? stage_q : pc_to_mem_o;
            end else begin : g_tail
                assign stage_d = stall_pc_i ? stage_q : pcq[gi-1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) stage_q <= '0;
                else     stage_q <= stage_d;
            end

            assign pcq[gi] = stage_q;
        end
    endgenerate

    always_comb begin
        fc_d = fc_q;
        if (br_taken_i) begin
            fc_d = FW'(FLUSH_CYCLES);
        end else if (fc_q != '0) begin
            fc_d = fc_q - FW'(1);
        end
        cnt_d = cnt_q;
        if (br_taken_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q  <= '0;
            cnt_q <= '0;
        end else begin
            fc_q  <= fc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_write_back_multi_port.sv
// Bench for write_back_multi_port: two instances (load latency 1 and 3) driven
// in parallel and checked every cycle against a queue/array reference model.
module tb_write_back_multi_port;

    localparam int DW = 64;
    localparam int RN = 32;
    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       wb_valid;
    logic [9:0]       wb_idx;
    logic [127:0]     wb_data;
    logic             efl_we;
    logic [63:0]      efl_data;
    logic             br_taken;
    logic [63:0]      br_target;
    logic             stall_pc;

    logic [RN*DW-1:0] gpr0, gpr1;
    logic [63:0]      mem0, mem1, fet0, fet1;
    logic             fl0, fl1;
    logic [31:0]      cnt0, cnt1;

    int total = 0;
    int bad   = 0;

    write_back_multi_port #(.LOAD_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
        .efl_we_i(efl_we), .efl_data_i(efl_data),
        .br_taken_i(br_taken), .br_target_i(br_target), .stall_pc_i(stall_pc),
        .gpr_o(gpr0), .pc_to_mem_o(mem0), .pc_to_fet_o(fet0),
        .flush_o(fl0), .redirect_cnt_o(cnt0)
    );

    write_back_multi_port #(.LOAD_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
        .efl_we_i(efl_we), .efl_data_i(efl_data),
        .br_taken_i(br_taken), .br_target_i(br_target), .stall_pc_i(stall_pc),
        .gpr_o(gpr1), .pc_to_mem_o(mem1), .pc_to_fet_o(fet1),
        .flush_o(fl1), .redirect_cnt_o(cnt1)
    );

    // Reference model: architectural registers, per-instance RIP and history of
    // issued PCs; flush derived from the cycle of the most recent redirect.
    logic [63:0] m_gpr [RN];
    logic [63:0] m_rip [2];
    logic [63:0] h0 [$];
    logic [63:0] h1 [$];
    int          cyc;
    int          last_br;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] m_fet(input int n);
        if (n == 0) return h0[h0.size()-1];
        return h1[h1.size()-3];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < RN; r++) m_gpr[r] = 64'd0;
        m_gpr[4] = 64'd1024;
        m_gpr[5] = 64'd1024;
        m_rip[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_rip[1] = 64'hFFFF_FFFF_FFFF_FFFD;
        h0 = {64'd0};
        h1 = {64'd0, 64'd0, 64'd0};
        cyc = 0;
        last_br = -100;
        m_cnt = 32'd0;
    endtask

    task automatic model_step();
        logic [63:0] f0, f1;
        f0 = m_fet(0);
        f1 = m_fet(1);
        for (int k = 0; k < 2; k++) begin
            if (wb_valid[k]) begin
                int ix;
                ix = int'(wb_idx[k*5 +: 5]);
                if (ix != 16) m_gpr[ix] = wb_data[k*64 +: 64];
            end
        end
        if (efl_we) m_gpr[17] = efl_data;
        if (!stall_pc) begin
            h0.push_back(m_rip[0]);
            h1.push_back(m_rip[1]);
        end
        while (h0.size() > 1) void'(h0.pop_front());
        while (h1.size() > 3) void'(h1.pop_front());
        m_rip[0] = br_taken ? br_target : (stall_pc ? f0 : m_rip[0] + 64'd1);
        m_rip[1] = br_taken ? br_target : (stall_pc ? f1 : m_rip[1] + 64'd1);
        cyc++;
        if (br_taken) begin
            last_br = cyc;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
    endtask

    task automatic check_all();
        logic [63:0] exp_fl;
        exp_fl = ((cyc - last_br) < FC) ? 64'd1 : 64'd0;
        chk("u0_flush", 64'(fl0), exp_fl);
        chk("u1_flush", 64'(fl1), exp_fl);
        chk("u0_cnt", 64'(cnt0), 64'(m_cnt));
        chk("u1_cnt", 64'(cnt1), 64'(m_cnt));
        chk("u0_pc_to_mem", mem0, m_rip[0]);
        chk("u1_pc_to_mem", mem1, m_rip[1]);
        chk("u0_pc_to_fet", fet0, m_fet(0));
        chk("u1_pc_to_fet", fet1, m_fet(1));
        for (int r = 0; r < RN; r++) begin
            chk($sformatf("u0_gpr%0d", r), gpr0[r*DW +: DW], (r == 16) ? m_rip[0] : m_gpr[r]);
            chk($sformatf("u1_gpr%0d", r), gpr1[r*DW +: DW], (r == 16) ? m_rip[1] : m_gpr[r]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        wb_valid  = 2'b00;
        wb_idx    = 10'd0;
        wb_data   = 128'd0;
        efl_we    = 1'b0;
        efl_data  = 64'd0;
        br_taken  = 1'b0;
        br_target = 64'd0;
        stall_pc  = 1'b0;
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] c0;

        idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        chk("rst_rip_l1", mem0, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_rip_l3", mem1, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("rst_rsp", gpr0[4*DW +: DW], 64'd1024);
        chk("rst_rbp", gpr0[5*DW +: DW], 64'd1024);
        chk("rst_flush", 64'(fl0), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("free_pc_to_mem", mem0, 64'(i));
            chk("free_pc_to_fet", fet0, 64'(i) - 64'd1);
        end

        wb_valid = 2'b11;
        wb_idx   = {5'd3, 5'd3};
        wb_data  = {64'hBB, 64'hAA};
        step();
        chk("conflict_hi_port", gpr0[3*DW +: DW], 64'hBB);
        prev     = mem0;
        wb_idx   = {5'd17, 5'd16};
        wb_data  = {64'h55, 64'h123};
        efl_we   = 1'b1;
        efl_data = 64'h77;
        step();
        chk("rip_write_ignored", mem0, prev + 64'd1);
        chk("efl_priority", gpr0[17*DW +: DW], 64'h77);
        idle();

        c0 = cnt0;
        br_taken  = 1'b1;
        br_target = 64'h40;
        stall_pc  = 1'b1;
        step();
        idle();
        chk("redir_rip", mem0, 64'h40);
        chk("redir_flush_1", 64'(fl0), 64'd1);
        chk("redir_cnt", 64'(cnt0), 64'(c0) + 64'd1);
        step();
        chk("redir_flush_2", 64'(fl0), 64'd1);
        step();
        chk("redir_flush_end", 64'(fl0), 64'd0);

        c0 = cnt0;
        br_taken  = 1'b1;
        br_target = 64'h100;
        step();
        chk("retrig_flush_1", 64'(fl0), 64'd1);
        br_target = 64'h200;
        step();
        idle();
        chk("retrig_flush_2", 64'(fl0), 64'd1);
        step();
        chk("retrig_flush_3", 64'(fl0), 64'd1);
        step();
        chk("retrig_flush_end", 64'(fl0), 64'd0);
        chk("retrig_cnt", 64'(cnt0), 64'(c0) + 64'd2);

        for (int i = 0; i < 4; i++) step();
        stall_pc = 1'b1;
        for (int i = 0; i < 4; i++) step();
        stall_pc = 1'b0;
        for (int i = 0; i < 6; i++) step();

        for (int i = 0; i < 400; i++) begin
            wb_valid  = 2'($urandom_range(0, 3));
            wb_idx    = 10'($urandom);
            wb_data   = {$urandom, $urandom, $urandom, $urandom};
            efl_we    = ($urandom_range(0, 3) == 0);
            efl_data  = {$urandom, $urandom};
            br_taken  = ($urandom_range(0, 7) == 0);
            br_target = {$urandom, $urandom};
            stall_pc  = ($urandom_range(0, 4) == 0);
            step();
        end
        idle();

        br_taken  = 1'b1;
        br_target = 64'h80;
        step();
        idle();
        chk("pre_async_flush", 64'(fl0), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_flush_drop", 64'(fl0), 64'd0);
        chk("async_rip_reset", mem0, 64'hFFFF_FFFF_FFFF_FFFF);
        model_reset();
        check_all();
        step();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
